echo_sequencer: RTL

ECHO_SEQUENCER -- requirements
Module: echo_sequencer

---
 rtl/echo_pkg.sv | 33 +++
 rtl/echo_mix.sv | 34 +++
 rtl/echo_sequencer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/echo_pkg.sv
// Shared definitions for the echo sequencer: top/sub-state encodings and
// saturation limits for signed sample arithmetic.
package echo_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RECORD  = 2'd1,
      ST_PROCESS = 2'd2,
      ST_PLAY    = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      SUB_RD_DLY = 2'd0,
      SUB_RD_CUR = 2'd1,
      SUB_WAIT   = 2'd2,
      SUB_WR     = 2'd3
   } sub_e;

   // Bit positions inside the packed {recEn, processEn, playEn} request vector
   localparam int unsigned EN_REC  = 2;
   localparam int unsigned EN_PROC = 1;
   localparam int unsigned EN_PLAY = 0;

   // Saturation limits for a signed value of width w (w <= 31)
   function automatic int sat_hi(input int unsigned w);
      return (1 << (w - 1)) - 1;
   endfunction

   function automatic int sat_lo(input int unsigned w);
      return -(1 << (w - 1));
   endfunction

endpackage

// File: rtl/echo_mix.sv
// Combinational echo mixer: cur + (dly >>> DECAY_SHIFT), saturated to the
// signed sample range.
module echo_mix
   import echo_pkg::*;
#(
   parameter int unsigned WORD_SIZE   = 16,
   parameter int unsigned DECAY_SHIFT = 1
) (
   input  logic signed [WORD_SIZE-1:0] cur_i,
   input  logic signed [WORD_SIZE-1:0] dly_i,
   output logic signed [WORD_SIZE-1:0] mix_c
);

   localparam int unsigned SW = WORD_SIZE + 1;
   localparam logic signed [SW-1:0] SAT_HI = SW'(sat_hi(WORD_SIZE));
   localparam logic signed [SW-1:0] SAT_LO = SW'(sat_lo(WORD_SIZE));

   logic signed [WORD_SIZE-1:0] dly_sh_c;
   logic signed [SW-1:0]        sum_c;

   // One guard bit makes the add exact; clamp afterwards
   always_comb begin
      dly_sh_c = dly_i >>> DECAY_SHIFT;
      sum_c    = {cur_i[WORD_SIZE-1], cur_i} + {dly_sh_c[WORD_SIZE-1], dly_sh_c};
      if (sum_c > SAT_HI) begin
         mix_c = SAT_HI[WORD_SIZE-1:0];
      end else if (sum_c < SAT_LO) begin
         mix_c = SAT_LO[WORD_SIZE-1:0];
      end else begin
         mix_c = sum_c[WORD_SIZE-1:0];
      end
   end

endmodule

// File: rtl/echo_sequencer.sv
// Record / echo-process / playback sequencer owning a single-port sample RAM
// with one-cycle read latency.
module echo_sequencer
   import echo_pkg::*;
#(
   parameter int unsigned WORD_SIZE   = 16,
   parameter int unsigned ADDR_WIDTH  = 14,
   parameter int unsigned DELAY       = 4096,
   parameter int unsigned DECAY_SHIFT = 1
) (
   input  logic                  inClock,
   input  logic                  resetN,
   input  logic                  recEn,
   input  logic                  processEn,
   input  logic                  playEn,
   input  logic                  sampleStrobe,
   input  logic [WORD_SIZE-1:0]  inSample,
   output logic [ADDR_WIDTH-1:0] memAddr,
   output logic                  memWrEn,
   output logic [WORD_SIZE-1:0]  memWrData,
   input  logic [WORD_SIZE-1:0]  memRdData,
   output logic [WORD_SIZE-1:0]  outSample,
   output logic                  outValid,
   output logic                  recDone,
   output logic                  processDone,
   output logic                  playDone,
   output logic                  busy
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_DELAY = ADDR_WIDTH'(DELAY);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);

   state_e                state_q, state_d;
   sub_e                  sub_q, sub_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic                  mem_wr_en_q, mem_wr_en_d;
   logic [WORD_SIZE-1:0]  mem_wr_data_q, mem_wr_data_d;
   logic [WORD_SIZE-1:0]  dly_q, dly_d;
   logic [WORD_SIZE-1:0]  out_sample_q, out_sample_d;
   logic                  out_valid_q, out_valid_d;
   logic                  rec_done_q, rec_done_d;
   logic                  proc_done_q, proc_done_d;
   logic                  play_done_q, play_done_d;
   logic                  busy_q, busy_d;
   logic                  fin_q, fin_d;
   logic [2:0]            en_prev_q, en_now_c, en_rise_c;
   logic [WORD_SIZE-1:0]  mix_c;

   echo_mix #(
      .WORD_SIZE   (WORD_SIZE),
      .DECAY_SHIFT (DECAY_SHIFT)
   ) u_mix (
      .cur_i (memRdData),
      .dly_i (dly_q),
      .mix_c (mix_c)
   );

   assign en_now_c  = {recEn, processEn, playEn};
   assign en_rise_c = en_now_c & ~en_prev_q;

   always_comb begin
      state_d       = state_q;
      sub_d         = sub_q;
      addr_d        = addr_q;
      mem_addr_d    = mem_addr_q;
      mem_wr_en_d   = 1'b0;
      mem_wr_data_d = mem_wr_data_q;
      dly_d         = dly_q;
      out_sample_d  = out_sample_q;
      out_valid_d   = 1'b0;
      rec_done_d    = rec_done_q;
      proc_done_d   = proc_done_q;
      play_done_d   = play_done_q;
      fin_d         = fin_q;

      unique case (state_q)
         ST_IDLE: begin
            if (en_rise_c[EN_REC] || en_rise_c[EN_PROC] || en_rise_c[EN_PLAY]) begin
               rec_done_d  = 1'b0;
               proc_done_d = 1'b0;
               play_done_d = 1'b0;
               fin_d       = 1'b0;
               mem_addr_d  = '0;
            end
            if (en_rise_c[EN_REC]) begin
               state_d = ST_RECORD;
               addr_d  = '0;
            end else if (en_rise_c[EN_PROC]) begin
               state_d = ST_PROCESS;
               sub_d   = SUB_RD_DLY;
               addr_d  = ADDR_DELAY;
            end else if (en_rise_c[EN_PLAY]) begin
               state_d = ST_PLAY;
               addr_d  = '0;
            end
         end

         // fin_q holds RECORD for the cycle the last write is on the bus
         ST_RECORD: begin
            if (!recEn) begin
               state_d = ST_IDLE;
               fin_d   = 1'b0;
            end else if (fin_q) begin
               state_d    = ST_IDLE;
               rec_done_d = 1'b1;
               fin_d      = 1'b0;
            end else if (sampleStrobe) begin
               mem_wr_en_d   = 1'b1;
               mem_wr_data_d = inSample;
               mem_addr_d    = addr_q;
               if (addr_q == ADDR_LAST) begin
                  fin_d = 1'b1;
               end else begin
                  addr_d = addr_q + ADDR_ONE;
               end
            end
         end

         ST_PROCESS: begin
            if (!processEn) begin
               state_d = ST_IDLE;
            end else begin
               unique case (sub_q)
                  SUB_RD_DLY: begin
                     mem_addr_d = addr_q;
                     sub_d      = SUB_RD_CUR;
                  end
                  SUB_RD_CUR: begin
                     dly_d = memRdData;
                     sub_d = SUB_WAIT;
                  end
                  SUB_WAIT: begin
                     mem_wr_en_d   = 1'b1;
                     mem_wr_data_d = mix_c;
                     sub_d         = SUB_WR;
                  end
                  SUB_WR: begin
                     if (addr_q == ADDR_LAST) begin
                        state_d     = ST_IDLE;
                        proc_done_d = 1'b1;
                     end else begin
                        addr_d     = addr_q + ADDR_ONE;
                        mem_addr_d = addr_q + ADDR_ONE - ADDR_DELAY;
                        sub_d      = SUB_RD_DLY;
                     end
                  end
                  default: sub_d = SUB_RD_DLY;
               endcase
            end
         end

         // memAddr is presented ahead of each strobe so read data is ready on it
         ST_PLAY: begin
            if (!playEn) begin
               state_d = ST_IDLE;
            end else if (sampleStrobe) begin
               out_sample_d = memRdData;
               out_valid_d  = 1'b1;
               if (addr_q == ADDR_LAST) begin
                  state_d     = ST_IDLE;
                  play_done_d = 1'b1;
               end else begin
                  addr_d     = addr_q + ADDR_ONE;
                  mem_addr_d = addr_q + ADDR_ONE;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge inClock or negedge resetN) begin
      if (!resetN) begin
         state_q       <= ST_IDLE;
         sub_q         <= SUB_RD_DLY;
         addr_q        <= '0;
         mem_addr_q    <= '0;
         mem_wr_en_q   <= 1'b0;
         mem_wr_data_q <= '0;
         dly_q         <= '0;
         out_sample_q  <= '0;
         out_valid_q   <= 1'b0;
         rec_done_q    <= 1'b0;
         proc_done_q   <= 1'b0;
         play_done_q   <= 1'b0;
         busy_q        <= 1'b0;
         fin_q         <= 1'b0;
         en_prev_q     <= '0;
      end else begin
         state_q       <= state_d;
         sub_q         <= sub_d;
         addr_q        <= addr_d;
         mem_addr_q    <= mem_addr_d;
         mem_wr_en_q   <= mem_wr_en_d;
         mem_wr_data_q <= mem_wr_data_d;
         dly_q         <= dly_d;
         out_sample_q  <= out_sample_d;
         out_valid_q   <= out_valid_d;
         rec_done_q    <= rec_done_d;
         proc_done_q   <= proc_done_d;
         play_done_q   <= play_done_d;
         busy_q        <= busy_d;
         fin_q         <= fin_d;
         en_prev_q     <= en_now_c;
      end
   end

   assign memAddr     = mem_addr_q;
   assign memWrEn     = mem_wr_en_q;
   assign memWrData   = mem_wr_data_q;
   assign outSample   = out_sample_q;
   assign outValid    = out_valid_q;
   assign recDone     = rec_done_q;
   assign processDone = proc_done_q;
   assign playDone    = play_done_q;
   assign busy        = busy_q;

endmodule
